// File: rtl/ok_trigout_pkg.sv
// Shared definitions for the Trigger Out collector: vector width, legal
// endpoint address window, FSM state encoding and the per-cycle control
// bundle that the FSM hands to the datapath.
package ok_trigout_pkg;

    // Width of the trigger vector and of every snapshot derived from it.
    localparam int TRIG_W = 32;

    // Trigger Out endpoints occupy this address window.
    localparam logic [7:0] TRIGOUT_ADDR_MIN = 8'h60;
    localparam logic [7:0] TRIGOUT_ADDR_MAX = 8'h7F;

    // IDLE: collecting, ready for a read. HOLD: snapshot presented to host.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } trigout_state_t;

    // One-hot-ish strobes decoded from the FSM for the current cycle.
    //   snap    : take the snapshot and clear the accumulators
    //   ack     : host consumed the snapshot, drop it
    //   restore : snapshot abandoned, fold it back into the accumulators
    typedef struct packed {
        logic snap;
        logic ack;
        logic restore;
    } trigout_ctrl_t;

    // Hold counter width; at least one bit so a disabled timeout still
    // yields a legal vector.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/ok_trig_accum.sv
// Sticky per-bit accumulator. Bits set by 'set' or 'restore' stay set until
// 'clear_all'. A clear wins over everything presented in the same cycle, so
// the caller must route a same-cycle pulse elsewhere (into the snapshot).
module ok_trig_accum
    import ok_trigout_pkg::*;
#(
    parameter int W = TRIG_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] set,
    input  logic         clear_all,
    input  logic [W-1:0] restore,
    output logic [W-1:0] q
);

    // Accumulate new pulses and restored bits; clear on snapshot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clear_all) begin
            q <= '0;
        end else begin
            q <= q | set | restore;
        end
    end

endmodule

// File: rtl/ok_trigger_out_collector.sv
// Trigger Out collector in the ep_clk domain.
//
// Single-cycle pulses on ep_trigger are latched into sticky pending bits.
// A matching rd_req snapshots (pend | ep_trigger) into rd_data and clears
// pend in the same cycle, so every pulse is reported exactly once. The
// snapshot is held (HOLD) until rd_ack; if the host never acknowledges
// within TIMEOUT cycles the snapshot is folded back into pend and
// timeout_err pulses.
//
// Handshake: rd_req is a one-cycle request, accepted only in IDLE with
// rd_addr == EP_ADDR. rd_valid is high exactly while the FSM is in HOLD and
// rd_data / rd_ovf are stable for that whole interval. rd_ack is only
// meaningful while rd_valid is high; rd_valid drops the cycle after it.
//
// Optional feature macro: OK_TRIGOUT_OVERFLOW_EN. When defined, an overflow
// vector records triggers that hit an already-pending bit and is reported
// on rd_ovf alongside rd_data. When undefined, rd_ovf is constant zero.
module ok_trigger_out_collector
    import ok_trigout_pkg::*;
#(
    parameter logic [7:0] EP_ADDR = 8'h60,
    parameter int         TIMEOUT = 1024
) (
    input  logic              ep_clk,
    input  logic              ep_rst_n,
    input  logic [TRIG_W-1:0] ep_trigger,
    input  logic              rd_req,
    input  logic [7:0]        rd_addr,
    input  logic              rd_ack,
    output logic              rd_valid,
    output logic [TRIG_W-1:0] rd_data,
    output logic [TRIG_W-1:0] rd_ovf,
    output logic              pending,
    output logic              timeout_err
);

    // Reject endpoint addresses outside the Trigger Out window at elaboration.
    if ((EP_ADDR < TRIGOUT_ADDR_MIN) || (EP_ADDR > TRIGOUT_ADDR_MAX)) begin : g_bad_ep_addr
        $error("ok_trigger_out_collector: EP_ADDR must lie in 0x60..0x7F");
    end

    localparam int               CNT_W      = cnt_width(TIMEOUT);
    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    trigout_state_t    state;
    trigout_state_t    state_next;
    trigout_ctrl_t     ctrl;
    logic [CNT_W-1:0]  cnt;
    logic [TRIG_W-1:0] pend;
    logic [TRIG_W-1:0] pend_restore;
    logic              addr_hit;
    logic              cnt_done;

    assign addr_hit = rd_req && (rd_addr == EP_ADDR);
    assign cnt_done = TIMEOUT_EN && (cnt == CNT_LAST);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge ep_clk) begin
        if (!ep_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a matching read enters HOLD; ack or timeout leaves it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (addr_hit) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (rd_ack || cnt_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath strobes; an ack in the timeout cycle wins over the restore.
    always_comb begin
        ctrl = '0;
        case (state)
            IDLE: begin
                ctrl.snap = addr_hit;
            end
            HOLD: begin
                ctrl.ack     = rd_ack;
                ctrl.restore = !rd_ack && cnt_done;
            end
            default: ctrl = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Hold counter: cleared on snapshot, counts HOLD cycles, saturates.
    always_ff @(posedge ep_clk) begin
        if (!ep_rst_n) begin
            cnt <= '0;
        end else if (ctrl.snap) begin
            cnt <= '0;
        end else if ((state == HOLD) && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Abandoned snapshot bits go back into pend alongside new pulses.
    assign pend_restore = ctrl.restore ? rd_data : '0;

    ok_trig_accum #(
        .W (TRIG_W)
    ) u_pend (
        .clk       (ep_clk),
        .rst_n     (ep_rst_n),
        .set       (ep_trigger),
        .clear_all (ctrl.snap),
        .restore   (pend_restore),
        .q         (pend)
    );

    // Snapshot register: loaded with this cycle's pulses too, dropped on exit.
    always_ff @(posedge ep_clk) begin
        if (!ep_rst_n) begin
            rd_data <= '0;
        end else if (ctrl.snap) begin
            rd_data <= pend | ep_trigger;
        end else if (ctrl.ack || ctrl.restore) begin
            rd_data <= '0;
        end
    end

    // One-cycle abandon indication, aligned with rd_valid falling.
    always_ff @(posedge ep_clk) begin
        if (!ep_rst_n) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= ctrl.restore;
        end
    end

    // HOLD is registered, so rd_valid is a clean flop output.
    assign rd_valid = (state == HOLD);
    assign pending  = |pend;

`ifdef OK_TRIGOUT_OVERFLOW_EN
    logic [TRIG_W-1:0] ovf;
    logic [TRIG_W-1:0] ovf_set;
    logic [TRIG_W-1:0] ovf_restore;

    // A pulse on a bit that is already pending is an overflow.
    assign ovf_set = ep_trigger & pend;

    // On abandon, restore the reported overflow plus any collision between
    // the returning snapshot and bits that became pending meanwhile.
    assign ovf_restore = ctrl.restore ? (rd_ovf | (rd_data & (pend | ep_trigger))) : '0;

    ok_trig_accum #(
        .W (TRIG_W)
    ) u_ovf (
        .clk       (ep_clk),
        .rst_n     (ep_rst_n),
        .set       (ovf_set),
        .clear_all (ctrl.snap),
        .restore   (ovf_restore),
        .q         (ovf)
    );

    // Overflow snapshot, taken and dropped together with rd_data.
    always_ff @(posedge ep_clk) begin
        if (!ep_rst_n) begin
            rd_ovf <= '0;
        end else if (ctrl.snap) begin
            rd_ovf <= ovf | ovf_set;
        end else if (ctrl.ack || ctrl.restore) begin
            rd_ovf <= '0;
        end
    end
`else
    assign rd_ovf = '0;
`endif

endmodule

// File: doc/ok_trigger_out_collector.md
# ok_trigger_out_collector

Synthesizable Trigger Out collector in the endpoint clock domain, the counterpart of the Trigger In endpoint. It latches single-cycle trigger pulses raised by user logic on `ep_clk` into sticky pending bits. A host-side poll then takes those bits with a request/valid/acknowledge handshake: the bits are snapshotted and cleared atomically, so no pulse is lost or reported twice. It sits between user logic and the host bridge, which has already moved host reads into `ep_clk`.

## Interface
Parameters:
- `EP_ADDR`, 8'h60: endpoint address. Must lie in 0x60–0x7F; any other value is an elaboration error.
- `TIMEOUT`, 1024: HOLD cycles allowed before an unacknowledged snapshot is abandoned. 0 disables the timeout.

Ports:
- `ep_clk` in 1: the only clock.
- `ep_rst_n` in 1: synchronous, active-low reset.
- `ep_trigger` in 32: trigger pulses from user logic. Each bit is one-cycle-significant.
- `rd_req` in 1: read request from the host bridge, one-cycle pulse.
- `rd_addr` in 8: address qualifying `rd_req`.
- `rd_ack` in 1: host has consumed `rd_data`.
- `rd_valid` out 1: snapshot is presented.
- `rd_data` out 32: snapshot of triggered bits.
- `rd_ovf` out 32: overflow snapshot. Tied to 0 unless the overflow feature is compiled in.
- `pending` out 1: OR of the pending bits.
- `timeout_err` out 1: one-cycle pulse when a snapshot is abandoned.

## Operation
- States: IDLE, HOLD.
- Accumulate, every cycle: `pend <= pend | ep_trigger`, except on snapshot or restore cycles (see below).
- IDLE, on `rd_req && rd_addr == EP_ADDR`:
  - `rd_data <= pend | ep_trigger` and `pend <= 0`, so the current-cycle trigger goes into the snapshot, not into `pend`.
  - `rd_valid <= 1`, state goes to HOLD, hold counter clears.
- IDLE, `rd_req` with a non-matching address: ignored.
- HOLD:
  - `pend` keeps accumulating new triggers.
  - `rd_req` is ignored.
  - `rd_data` is held stable.
- HOLD, on `rd_ack`: `rd_valid <= 0`, `rd_data <= 0`, state goes to IDLE.
- HOLD timeout (`TIMEOUT != 0` and counter reaches `TIMEOUT-1` without `rd_ack`):
  - `pend <= pend | ep_trigger | rd_data`, restoring the bits.
  - `rd_valid <= 0`, `timeout_err` pulses, state goes to IDLE.
- `rd_ack` and timeout on the same cycle: the ack wins, no restore and no `timeout_err`.
- `rd_ack` while in IDLE: ignored.
- Reset values: state IDLE, `pend` 0, `rd_valid` 0, `rd_data` 0, `rd_ovf` 0, `pending` 0, `timeout_err` 0, counter 0.
- Reset asserted mid-HOLD: the snapshot and all pending bits are discarded.
- Hold counter is `$clog2(TIMEOUT+1)` bits and saturates; it never wraps.

## Timing
- Latency is one cycle from a matching `rd_req` to `rd_valid` = 1 with `rd_data` valid.
- `rd_valid` falls on the cycle after `rd_ack` is sampled.
- The earliest next accepted `rd_req` is the cycle after `rd_valid` falls.
- A trigger is visible on `pending` one cycle after its pulse.
- A trigger arriving in the acknowledge cycle goes into `pend` and is never lost.
- `rd_ovf` is presented on the same cycle as `rd_data`.

## Configuration
- Macro `OK_TRIGOUT_OVERFLOW_EN` defined:
  - An `ovf` register sets bit i when `ep_trigger[i]` arrives while `pend[i]` is already 1.
  - `ovf` is snapshotted and cleared with `rd_data` and drives `rd_ovf`.
  - On timeout it is restored by OR, the same way as `pend`.
- Macro undefined: no `ovf` register, `rd_ovf` is constant 0, and the port remains present.

## Structure
- Package `ok_trigout_pkg` holds:
  - the state enum `trigout_state_t` (IDLE, HOLD);
  - `TRIGOUT_ADDR_MIN` = 8'h60 and `TRIGOUT_ADDR_MAX` = 8'h7F;
  - `TRIG_W` = 32.
- Sub-module `ok_trig_accum`: per-vector sticky accumulator with `set`, `clear_all` and `restore` inputs. It is instantiated for `pend` and, when the macro is defined, for `ovf`.

## Test plan
- Pulse `ep_trigger` = 32'h0000_0005, then `rd_req` at 8'h60 → next cycle `rd_valid` = 1, `rd_data` = 32'h5, `pending` = 0.
- `rd_req` and `ep_trigger` = 32'h8000_0000 on the same cycle, with `pend` = 32'h1 → `rd_data` = 32'h8000_0001.
- Trigger 32'h10 during HOLD, then `rd_ack` → `rd_valid` falls, `pending` = 1; a second read returns 32'h10.
- `TIMEOUT` = 4, `pend` = 32'h3, no ack → `timeout_err` pulses 4 cycles after `rd_valid` rises, `rd_valid` = 0; a re-read returns 32'h3.
- With `OK_TRIGOUT_OVERFLOW_EN`: bit 2 pulsed twice before the read → `rd_data` = 32'h4, `rd_ovf` = 32'h4. Without the macro → `rd_ovf` = 0.
- `ep_rst_n` low during HOLD → next cycle `rd_valid` = 0 and `pending` = 0; a following read returns 0.
